// File: rtl/pipe_adder.sv
`default_nettype none
//==============================================================================
// Module      : pipe_adder
// Description : Pipelined WIDTH-bit ripple-carry adder, one SW-bit slice per
//               stage, valid/ready handshake with whole-pipeline stall.
//               Optional subtract mode enabled by defining PIPE_ADDER_SUB_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int c_SW = WIDTH / STAGES;

    logic             w_en;
    logic             r_in_valid;
    logic [WIDTH-1:0] r_in_a;
    logic [WIDTH-1:0] r_in_b;
    logic             r_in_carry;
`ifdef PIPE_ADDER_SUB_EN
    logic             r_in_sub;
`endif

    // A held result freezes every register in the block, including capture.
    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_valid <= 1'b0;
            r_in_a     <= '0;
            r_in_b     <= '0;
            r_in_carry <= 1'b0;
`ifdef PIPE_ADDER_SUB_EN
            r_in_sub   <= 1'b0;
`endif
        end else if (w_en) begin
            r_in_valid <= in_valid;
            r_in_a     <= a;
            r_in_b     <= b;
`ifdef PIPE_ADDER_SUB_EN
            r_in_sub   <= sub;
            r_in_carry <= sub | ci;
`else
            r_in_carry <= ci;
`endif
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unconsumed when entering stage k.
        localparam int c_REM = (STAGES - k) * c_SW;

        logic [c_REM-1:0]      w_a;
        logic [c_REM-1:0]      w_b;
        logic                  w_cin;
        logic                  w_vin;
        logic [c_SW-1:0]       w_b_slice;
        logic [c_SW:0]         w_slice;
        logic [(k+1)*c_SW-1:0] w_sum_next;
        logic [(k+1)*c_SW-1:0] r_sum;
        logic                  r_carry;
        logic                  r_valid;
`ifdef PIPE_ADDER_SUB_EN
        logic                  w_sub;
`endif

        if (k == 0) begin : g_first
            assign w_a        = r_in_a;
            assign w_b        = r_in_b;
            assign w_cin      = r_in_carry;
            assign w_vin      = r_in_valid;
            assign w_sum_next = w_slice[c_SW-1:0];
`ifdef PIPE_ADDER_SUB_EN
            assign w_sub      = r_in_sub;
`endif
        end else begin : g_next
            assign w_a        = g_stage[k-1].g_skew.r_a;
            assign w_b        = g_stage[k-1].g_skew.r_b;
            assign w_cin      = g_stage[k-1].r_carry;
            assign w_vin      = g_stage[k-1].r_valid;
            assign w_sum_next = {w_slice[c_SW-1:0], g_stage[k-1].r_sum};
`ifdef PIPE_ADDER_SUB_EN
            assign w_sub      = g_stage[k-1].g_skew.r_sub;
`endif
        end

`ifdef PIPE_ADDER_SUB_EN
        assign w_b_slice = w_b[c_SW-1:0] ^ {c_SW{w_sub}};
`else
        assign w_b_slice = w_b[c_SW-1:0];
`endif
        assign w_slice = {1'b0, w_a[c_SW-1:0]} + {1'b0, w_b_slice}
                       + {{c_SW{1'b0}}, w_cin};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_en) begin
                r_valid <= w_vin;
                r_carry <= w_slice[c_SW];
                r_sum   <= w_sum_next;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [c_REM-c_SW-1:0] r_a;
            logic [c_REM-c_SW-1:0] r_b;
`ifdef PIPE_ADDER_SUB_EN
            logic                  r_sub;
`endif
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a   <= '0;
                    r_b   <= '0;
`ifdef PIPE_ADDER_SUB_EN
                    r_sub <= 1'b0;
`endif
                end else if (w_en) begin
                    r_a   <= w_a[c_REM-1:c_SW];
                    r_b   <= w_b[c_REM-1:c_SW];
`ifdef PIPE_ADDER_SUB_EN
                    r_sub <= w_sub;
`endif
                end
            end
        end else begin : g_last
            logic r_ovf;
            // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= (w_slice[c_SW-1] ^ w_a[c_SW-1] ^ w_b_slice[c_SW-1])
                           ^ w_slice[c_SW];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign co        = g_stage[STAGES-1].r_carry;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipe_adder
// Description : Self-checking bench for pipe_adder against an arithmetic
//               reference model; covers PIPE_ADDER_SUB_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipe_adder;

    localparam int c_WIDTH  = 32;
    localparam int c_STAGES = 4;

    logic               clk       = 1'b0;
    logic               reset     = 1'b1;
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [c_WIDTH-1:0] a         = '0;
    logic [c_WIDTH-1:0] b         = '0;
    logic               ci        = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
    logic               sub       = 1'b0;
`endif
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [c_WIDTH-1:0] sum;
    logic               co;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    logic [c_WIDTH+1:0] exp_q[$];
    logic               obs_valid;
    logic               obs_ready;
    logic [c_WIDTH-1:0] obs_sum;
    logic               obs_co;
    logic               obs_ovf;

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH  (c_WIDTH),
        .STAGES (c_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    // Reference: {ovf, co, sum} of a single wide add or subtract.
    function automatic logic [c_WIDTH+1:0] model(input logic [c_WIDTH-1:0] x,
                                                 input logic [c_WIDTH-1:0] y,
                                                 input logic c, input logic s);
        logic [c_WIDTH:0] full;
        logic             v;
        if (s) full = {1'b0, x} - {1'b0, y} + {1'b1, {c_WIDTH{1'b0}}};
        else   full = {1'b0, x} + {1'b0, y} + c_WIDTH'(c);
        if (s) v = (x[c_WIDTH-1] != y[c_WIDTH-1]) && (full[c_WIDTH-1] != x[c_WIDTH-1]);
        else   v = (x[c_WIDTH-1] == y[c_WIDTH-1]) && (full[c_WIDTH-1] != x[c_WIDTH-1]);
        return {v, full};
    endfunction

    // Samples outputs at the falling edge, then drives the next cycle's inputs.
    task automatic drive_cycle(input logic iv, input logic [c_WIDTH-1:0] x,
                               input logic [c_WIDTH-1:0] y, input logic c,
                               input logic s, input logic ordy);
        @(negedge clk);
        obs_valid = out_valid;
        obs_sum   = sum;
        obs_co    = co;
        obs_ovf   = ovf;
        in_valid  = iv;
        a         = x;
        b         = y;
        ci        = c;
`ifdef PIPE_ADDER_SUB_EN
        sub       = s;
`endif
        out_ready = ordy;
        #1;
        obs_ready = in_ready;
        if (iv && in_ready) exp_q.push_back(model(x, y, c, s));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (sum !== '0)         begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
        checks++; if (co !== 1'b0)        begin errors++; $display("FAIL reset_co got %0b want 0", co); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [c_WIDTH-1:0] va[4], vb[4], vsum[4];
        logic               vc[4], vs[4], vco[4], vov[4];
        int                 n;
        int                 lat;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vc[0] = 0; vs[0] = 0;
        vsum[0] = 32'h0000_0000; vco[0] = 1; vov[0] = 0;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 0; vs[1] = 0;
        vsum[1] = 32'h8000_0000; vco[1] = 0; vov[1] = 1;
        va[2] = 32'h0000_0005; vb[2] = 32'h0000_0007; vc[2] = 0; vs[2] = 1;
        vsum[2] = 32'hFFFF_FFFE; vco[2] = 0; vov[2] = 0;
        va[3] = 32'h8000_0000; vb[3] = 32'h0000_0001; vc[3] = 1; vs[3] = 1;
        vsum[3] = 32'h7FFF_FFFF; vco[3] = 1; vov[3] = 1;
        n = 2;
`ifdef PIPE_ADDER_SUB_EN
        n = 4;
`endif
        for (int i = 0; i < n; i++) begin
            exp_q.delete();
            drive_cycle(1'b1, va[i], vb[i], vc[i], vs[i], 1'b1);
            lat = 0;
            for (int j = 1; j <= 20; j++) begin
                drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
                if (obs_valid) begin lat = j; break; end
            end
            checks++; if (lat != c_STAGES + 1) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d (0 = timeout)", i, lat, c_STAGES + 1); end
            checks++; if (obs_sum !== vsum[i]) begin errors++; $display("FAIL directed%0d_sum got %h want %h", i, obs_sum, vsum[i]); end
            checks++; if (obs_co !== vco[i])   begin errors++; $display("FAIL directed%0d_co got %0b want %0b", i, obs_co, vco[i]); end
            checks++; if (obs_ovf !== vov[i])  begin errors++; $display("FAIL directed%0d_ovf got %0b want %0b", i, obs_ovf, vov[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [c_WIDTH+1:0] e;
        logic               sbr;
        int                 got, first, last;
        exp_q.delete();
        got = 0; first = -1; last = -1;
        for (int i = 0; i < 30; i++) begin
            sbr = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
            sbr = 1'($urandom_range(1));
`endif
            if (i < 8) drive_cycle(1'b1, $urandom, $urandom, 1'($urandom), sbr, 1'b1);
            else       drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (obs_valid) begin
                if (first < 0) first = i;
                last = i;
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got result %h want none", obs_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_ovf, obs_co, obs_sum} !== e) begin
                        errors++; $display("FAIL b2b_result got %h want %h", {obs_ovf, obs_co, obs_sum}, e);
                    end
                end
            end
        end
        checks++; if (first != c_STAGES + 1) begin errors++; $display("FAIL b2b_first got %0d want %0d", first, c_STAGES + 1); end
        checks++; if (got != 8)              begin errors++; $display("FAIL b2b_count got %0d want 8", got); end
        checks++; if (last - first != 7)     begin errors++; $display("FAIL b2b_span got %0d want 7", last - first); end
    endtask

    task automatic test_backpressure();
        logic [c_WIDTH-1:0] op_a[7], op_b[7];
        logic               op_c[7];
        logic [c_WIDTH+1:0] e;
        logic [c_WIDTH-1:0] prev_sum;
        logic               prev_hold, ordy, iv;
        int                 ptr, got;
        for (int i = 0; i < 7; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = 1'($urandom);
        end
        exp_q.delete();
        ptr = 0; got = 0; prev_hold = 1'b0; prev_sum = '0;
        for (int i = 0; i < 40; i++) begin
            ordy = !(i >= c_STAGES + 1 && i < c_STAGES + 4);
            iv   = (ptr < 6);
            drive_cycle(iv, op_a[ptr], op_b[ptr], op_c[ptr], 1'b0, ordy);
            if (iv && obs_ready) ptr++;
            checks++;
            if (obs_ready !== !(obs_valid && !ordy)) begin
                errors++; $display("FAIL bp_in_ready cycle %0d got %0b want %0b", i, obs_ready, !(obs_valid && !ordy));
            end
            if (prev_hold) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_sum !== prev_sum) begin
                    errors++; $display("FAIL bp_hold cycle %0d got valid %0b sum %h want valid 1 sum %h", i, obs_valid, obs_sum, prev_sum);
                end
            end
            if (obs_valid && ordy) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra got result %h want none", obs_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_ovf, obs_co, obs_sum} !== e) begin
                        errors++; $display("FAIL bp_result got %h want %h", {obs_ovf, obs_co, obs_sum}, e);
                    end
                end
            end
            prev_hold = obs_valid && !ordy;
            prev_sum  = obs_sum;
        end
        checks++; if (got != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got); end
        checks++; if (ptr != 6) begin errors++; $display("FAIL bp_accepted got %0d want 6", ptr); end
    endtask

    task automatic test_reset_midflight();
        int stale;
        exp_q.delete();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, $urandom | 32'h1, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0b want 1", obs_valid); end
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b want 0", out_valid); end
        checks++; if (sum !== '0)         begin errors++; $display("FAIL rst_async_sum got %h want 0", sum); end
        checks++; if (co !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_async_flags got %0b%0b want 00", co, ovf); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (obs_valid) stale++;
        end
        checks++; if (stale != 0)         begin errors++; $display("FAIL rst_stale got %0d want 0", stale); end
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", obs_ready); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined N-bit ripple-carry adder for the datapath, built as the multi-bit successor of the team's single-bit full-adder cell. Operands are split into equal slices. Each pipeline stage adds one slice with a registered carry from the previous stage, so timing closes at any width. A valid/ready handshake with whole-pipeline stall lets the block sit between pipeline registers of the processor or feed a consumer that can back-pressure.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES
- STAGES, 4, number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all valid and output state
- in_valid  input  1  operand set present on a, b, ci (and sub)
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in, used in add mode
- sub  input  1  subtract mode select; present only with PIPE_ADDER_SUB_EN
- out_valid  output  1  sum/co/ovf hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- sum  output  WIDTH  result bits
- co  output  1  carry-out of bit WIDTH-1
- ovf  output  1  two's-complement overflow: carry into bit WIDTH-1 XOR co

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Stage k (0..STAGES-1) adds slice bits [k*SW +: SW] of a and b, using the registered carry from stage k-1. Stage 0 uses the effective carry-in.
- Operand slices not yet consumed are carried forward in skew registers. Completed sum slices are carried forward in de-skew registers, so all WIDTH sum bits leave the last stage together.
- Each stage holds a valid bit. Nothing else needs a state machine: control is the valid shift chain plus one global enable.
- Global enable en = !(out_valid && !out_ready). When en=0, every stage register, valid bit and output holds.
- in_ready = en. This is combinational from out_valid/out_ready, and out_valid is registered, so there is no comb path from in_valid.
- Bubbles are not collapsed: an invalid stage still advances when en=1.
- Arithmetic is modulo 2^WIDTH. sum, co and ovf match a single-cycle WIDTH-bit add of the same operands exactly.
- ovf is computed in the last stage from the carry into the MSB and co.

## Timing
- Reset (async assert, released synchronously to clk by the system): all stage valid bits = 0; out_valid=0, sum=0, co=0, ovf=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight operations. Nothing is emitted for them after release.
- Latency: an operation accepted at edge n shows out_valid=1 with its result after edge n+STAGES, provided no stall occurs.
- Throughput: 1 operation/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, the outputs stay constant and in_ready=0. On the cycle out_ready rises, the result transfers and the pipeline advances at the same edge.
- Simultaneous in and out transfer in the same cycle is legal and is the steady state.
- STAGES=1: a single registered adder with latency 1. STAGES=WIDTH: a bit-serial-style pipeline, 1 bit per stage.

## Configuration
- PIPE_ADDER_SUB_EN defined:
  - port sub exists and is captured with the operands, travelling in the skew chain.
  - sub=1: b is inverted slice-wise, the effective carry-in is forced to 1 and ci is ignored; the result is a-b.
  - co=1 means no borrow. ovf is signed subtract overflow.
- PIPE_ADDER_SUB_EN undefined: no sub port; the block is a pure adder and the effective carry-in = ci.

## Test plan
- WIDTH=32, STAGES=4, out_ready=1: single add a=0xFFFFFFFF, b=0x00000001, ci=0 -> after 4 edges sum=0x00000000, co=1, ovf=0. This checks carry rippling across all slice boundaries.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, ci=0 -> sum=0x80000000, co=0, ovf=1.
- Back-to-back stream of 8 random operand sets with out_ready=1 -> 8 consecutive out_valid cycles starting 4 cycles after the first accept, each matching the reference a+b+ci.
- Backpressure: stream 6 operations while holding out_ready=0 for 3 cycles after the first result appears -> in_ready=0 and sum stable during the hold; no result lost or duplicated; order preserved.
- Reset asserted with 3 operations in flight -> out_valid=0 and sum=0 immediately; after release no stale result is emitted and in_ready=1.
- PIPE_ADDER_SUB_EN: a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, co=0, ovf=0. a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, co=1, ovf=1.
